char_row_fetch: RTL and testbench

- Upstream feeder for the line serializer stage. Holds one text line of character codes and, per font scan row, fetches glyph bytes from an external font ROM.
- Assembles each scan row into a double-buffered row_data word. Hands rows out one at a time through a valid/ready handshake.
- The serializer consumes row_data MSB-first, so row_data stays stable for the whole time a row is being shifted out.

---
 rtl/char_row_fetch_if.sv | 10 +
 rtl/char_row_fetch.sv | 95 +++++++++
 tb/tb_char_row_fetch.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/char_row_fetch_if.sv
// char_row_fetch_if: scan-row output handshake between char_row_fetch and the line serializer
interface char_row_fetch_if #(
    parameter int CHAR_NUM = 16
);
    logic [CHAR_NUM*8-1:0] row_data;
    logic row_valid;
    logic row_ready;
    modport master (output row_data, output row_valid, input row_ready);
    modport slave (input row_data, input row_valid, output row_ready);
endinterface

// File: rtl/char_row_fetch.sv
// char_row_fetch: fetches glyph bytes per scan row into a double-buffered row word.
// Define CHAR_CURSOR_EN to add an underline cursor on the last two scan rows.
module char_row_fetch #(
    parameter int CHAR_NUM = 16,
    parameter int FONT_H = 16,
    parameter int ROW_W = 4,
    parameter int IDX_W = 4
) (
    input  logic bit_clk,
    input  logic reset_p,
    input  logic wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [7:0] wr_char,
    input  logic line_start,
    output logic [7+ROW_W:0] font_addr,
    input  logic [7:0] font_data,
`ifdef CHAR_CURSOR_EN
    input  logic cursor_on,
    input  logic [IDX_W-1:0] cursor_idx,
`endif
    output logic busy,
    output logic line_done,
    char_row_fetch_if.master row
);
    typedef enum logic [1:0] {IDLE, FETCH, FULL} state_t;
    localparam logic [IDX_W:0] CN = (IDX_W+1)'(CHAR_NUM);
    localparam logic [ROW_W-1:0] LAST = ROW_W'(FONT_H-1);
    state_t state;
    logic [7:0] txt [CHAR_NUM];
    logic [IDX_W:0] cnt;
    logic [ROW_W-1:0] row_idx;
    logic [CHAR_NUM*8-1:0] shadow;
    logic [7+ROW_W:0] addr_q;
    logic [7:0] cap;
    logic addr_cyc, free;
    // Address is read straight from the buffer so a write landing before its cycle is honoured
    assign addr_cyc = state == FETCH && cnt < CN;
    assign font_addr = addr_cyc ? {txt[cnt[IDX_W-1:0]], row_idx} : addr_q;
    assign free = !row.row_valid || row.row_ready;
    assign busy = state != IDLE;
`ifdef CHAR_CURSOR_EN
    assign cap = cursor_on && {1'b0, cursor_idx} == cnt - 1'b1 && row_idx >= LAST - 1'b1 ? 8'hFF : font_data;
`else
    assign cap = font_data;
`endif
    always_ff @(posedge bit_clk or posedge reset_p) begin
        if (reset_p) begin
            for (int i = 0; i < CHAR_NUM; i++) txt[i] <= 8'h20;
        end else if (wr_en && {1'b0, wr_idx} < CN) begin
            txt[wr_idx] <= wr_char;
        end
    end
    always_ff @(posedge bit_clk or posedge reset_p) begin
        if (reset_p) begin
            state <= IDLE;
            cnt <= '0;
            row_idx <= '0;
            shadow <= '0;
            addr_q <= '0;
            line_done <= 1'b0;
            row.row_data <= '0;
            row.row_valid <= 1'b0;
        end else begin
            line_done <= 1'b0;
            if (addr_cyc) addr_q <= font_addr;
            if (row.row_valid && row.row_ready) row.row_valid <= 1'b0;
            case (state)
                IDLE: if (line_start) begin
                    state <= FETCH;
                    cnt <= '0;
                    row_idx <= '0;
                end
                FETCH: begin
                    cnt <= cnt + 1'b1;
                    // Bytes shift in from the right so char 0 ends up in the top byte
                    if (cnt != '0) shadow <= {shadow[CHAR_NUM*8-9:0], cap};
                    if (cnt == CN) state <= FULL;
                end
                FULL: if (free) begin
                    row.row_data <= shadow;
                    row.row_valid <= 1'b1;
                    cnt <= '0;
                    if (row_idx == LAST) begin
                        line_done <= 1'b1;
                        state <= IDLE;
                    end else begin
                        row_idx <= row_idx + 1'b1;
                        state <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_char_row_fetch.sv
// tb_char_row_fetch: randomized bench comparing each presented scan row against a
// row-level model built from the text buffer contents and a font ROM function.
`timescale 1ns/1ps
module tb_char_row_fetch;
    localparam int CN = 16;
    localparam int FH = 16;
    logic bit_clk = 1'b0;
    logic reset_p = 1'b1;
    logic wr_en = 1'b0;
    logic [3:0] wr_idx = '0;
    logic [7:0] wr_char = '0;
    logic line_start = 1'b0;
    logic [11:0] font_addr;
    logic [7:0] font_data = '0;
    logic busy, line_done;
`ifdef CHAR_CURSOR_EN
    logic cursor_on = 1'b0;
    logic [3:0] cursor_idx = '0;
`endif
    int errors = 0;
    int checks = 0;
    logic [7:0] txt [CN];
    char_row_fetch_if #(.CHAR_NUM(CN)) row_if ();
    char_row_fetch #(.CHAR_NUM(CN), .FONT_H(FH), .ROW_W(4), .IDX_W(4)) dut (
        .bit_clk(bit_clk),
        .reset_p(reset_p),
        .wr_en(wr_en),
        .wr_idx(wr_idx),
        .wr_char(wr_char),
        .line_start(line_start),
        .font_addr(font_addr),
        .font_data(font_data),
`ifdef CHAR_CURSOR_EN
        .cursor_on(cursor_on),
        .cursor_idx(cursor_idx),
`endif
        .busy(busy),
        .line_done(line_done),
        .row(row_if)
    );
    always #5 bit_clk = ~bit_clk;
    // Font ROM: mixes code and row so every byte depends on both
    function automatic logic [7:0] rom(input logic [11:0] a);
        return a[11:4] ^ {a[3:0], ~a[3:0]} ^ 8'h5A;
    endfunction
    always @(posedge bit_clk) font_data <= rom(font_addr);
    function automatic logic [127:0] exp_row(input int r);
        logic [127:0] v;
        logic [7:0] b;
        v = '0;
        for (int i = 0; i < CN; i++) begin
            b = rom({txt[i], 4'(r)});
`ifdef CHAR_CURSOR_EN
            if (cursor_on && int'(cursor_idx) == i && r >= FH-2) b = 8'hFF;
`endif
            v[127-8*i -: 8] = b;
        end
        return v;
    endfunction
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge bit_clk);
        #1;
    endtask
    task automatic wr(input int i, input logic [7:0] c);
        wr_en = 1'b1;
        wr_idx = 4'(i);
        wr_char = c;
        step();
        wr_en = 1'b0;
        txt[i] = c;
    endtask
    task automatic fill_random();
        for (int i = 0; i < CN; i++) wr(i, 8'($urandom));
    endtask
    task automatic start();
        line_start = 1'b1;
        step();
        line_start = 1'b0;
    endtask
    task automatic wait_row(input int r, input int lat);
        int n;
        n = 0;
        while (!row_if.row_valid && n < 200) begin
            step();
            n++;
        end
        check($sformatf("row%0d_valid", r), row_if.row_valid, 1);
        if (lat >= 0) check("latency", n, lat);
        check($sformatf("row%0d_data", r), row_if.row_data, exp_row(r));
        check($sformatf("row%0d_line_done", r), line_done, r == FH-1);
    endtask
    task automatic run_rest(input int from);
        for (int r = from; r < FH; r++) begin
            step();
            wait_row(r, -1);
        end
        check("busy_after_line", busy, 0);
        step();
        check("line_done_single", line_done, 0);
    endtask
    initial begin
        int r, cyc;
        for (int i = 0; i < CN; i++) txt[i] = 8'h20;
        row_if.row_ready = 1'b1;
        repeat (3) @(posedge bit_clk);
        #1 reset_p = 1'b0;
        step();
        check("rst_valid", row_if.row_valid, 0);
        check("rst_data", row_if.row_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", line_done, 0);
        check("rst_addr", font_addr, 0);
        // Untouched buffer holds spaces
        start();
        check("busy_fetch", busy, 1);
        wait_row(0, CN + 2);
        run_rest(1);
        // "A".."P"
        for (int i = 0; i < CN; i++) wr(i, 8'h41 + 8'(i));
        start();
        wait_row(0, CN + 2);
        check("r0b0", row_if.row_data[127:120], rom({8'h41, 4'h0}));
        run_rest(1);
        // Back-pressure, accept-and-load without bubble, ignored line_start while busy
        fill_random();
        row_if.row_ready = 1'b0;
        start();
        wait_row(0, CN + 2);
        repeat (30) step();
        check("hold_data", row_if.row_data, exp_row(0));
        check("hold_valid", row_if.row_valid, 1);
        check("hold_busy", busy, 1);
        row_if.row_ready = 1'b1;
        step();
        row_if.row_ready = 1'b0;
        wait_row(1, 0);
        start();
        repeat (25) step();
        check("hold1_data", row_if.row_data, exp_row(1));
        row_if.row_ready = 1'b1;
        run_rest(2);
        // Write to slot 15 during fetch cycle 3 of row 0
        fill_random();
        start();
        step();
        step();
        step();
        wr(15, 8'($urandom));
        wait_row(0, -1);
        run_rest(1);
        // Reset while fetching row 5
        fill_random();
        start();
        wait_row(0, CN + 2);
        for (int k = 1; k < 5; k++) begin
            step();
            wait_row(k, -1);
        end
        repeat (6) step();
        reset_p = 1'b1;
        #1;
        check("mid_rst_valid", row_if.row_valid, 0);
        check("mid_rst_data", row_if.row_data, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_addr", font_addr, 0);
        for (int i = 0; i < CN; i++) txt[i] = 8'h20;
        step();
        reset_p = 1'b0;
        step();
        start();
        wait_row(0, CN + 2);
        run_rest(1);
        // Random ready pattern, rows checked as they are accepted
        fill_random();
        start();
        r = 0;
        cyc = 0;
        while (r < FH && cyc < 3000) begin
            row_if.row_ready = 1'($urandom_range(0, 1));
            if (row_if.row_valid && row_if.row_ready) begin
                check($sformatf("rand_row%0d", r), row_if.row_data, exp_row(r));
                r++;
            end
            step();
            cyc++;
        end
        check("rand_rows", r, FH);
        row_if.row_ready = 1'b1;
        repeat (3) step();
`ifdef CHAR_CURSOR_EN
        cursor_on = 1'b1;
        cursor_idx = 4'd3;
        fill_random();
        start();
        wait_row(0, CN + 2);
        run_rest(1);
        cursor_idx = 4'($urandom);
        start();
        wait_row(0, CN + 2);
        run_rest(1);
        cursor_on = 1'b0;
        start();
        wait_row(0, CN + 2);
        run_rest(1);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
